// File: rtl/spi_lcd_rx.sv
// SPI receive front end for an ST7789-style display command stream.
// Oversamples SCLK/CS/MOSI/DC in i_clk, decodes CASET/RASET/RAMWR/RAMWRC and emits addressed pixels.
module spi_lcd_rx #(
    parameter int PIX_BITS    = 16,
    parameter int H_RES       = 480,
    parameter int V_RES       = 272,
    parameter int SYNC_STAGES = 2,
    localparam int XW = $clog2(H_RES),
    localparam int YW = $clog2(V_RES)
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_spi_clk,
    input  logic                i_spi_cs,
    input  logic                i_spi_mosi,
    input  logic                i_spi_dc,
    output logic [PIX_BITS-1:0] o_pixel_data,
    output logic [XW-1:0]       o_pixel_x,
    output logic [YW-1:0]       o_pixel_y,
    output logic                o_pixel_en_pls,
    output logic                o_vsync_pls
);
    localparam logic [1:0]  ST_IDLE   = 2'd0;
    localparam logic [1:0]  ST_CASET  = 2'd1;
    localparam logic [1:0]  ST_RASET  = 2'd2;
    localparam logic [1:0]  ST_PIXEL  = 2'd3;
    localparam logic [1:0]  LAST_IDX  = (PIX_BITS == 16) ? 2'd1 : 2'd2;
    localparam logic [15:0] X_MAX     = 16'(H_RES - 1);
    localparam logic [15:0] Y_MAX     = 16'(V_RES - 1);

    logic [SYNC_STAGES-1:0] r_sclk_sync, r_cs_sync, r_mosi_sync, r_dc_sync;
    logic                   r_sclk_hist, r_cs_hist;
    logic [6:0]             r_shift;
    logic [2:0]             r_bit_cnt;
    logic [1:0]             r_state, r_byte_idx;
    logic [23:0]            r_par;
    logic [XW-1:0]          r_xs, r_xe, r_x;
    logic [YW-1:0]          r_ys, r_ye, r_y;

    logic                   w_sclk, w_cs, w_mosi, w_dc, w_rise, w_byte_done;
    logic [7:0]             w_byte;
    logic [15:0]            w_lim, w_start, w_end, w_s_clamp, w_e_clamp, w_e_fix;
    logic [PIX_BITS-1:0]    w_pix;
    logic [XW-1:0]          w_x_next;
    logic [YW-1:0]          w_y_next;

    assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs        = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
    assign w_dc        = r_dc_sync[SYNC_STAGES-1];
    // Gating on the CS history lets a byte finish in the cycle CS is seen rising.
    assign w_rise      = w_sclk & ~r_sclk_hist & ~r_cs_hist;
    assign w_byte_done = w_rise & (r_bit_cnt == 3'd7);
    assign w_byte      = {r_shift, w_mosi};

    // Synchronisers and history flops for the SPI pins; CS idles inactive.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '1;
            r_mosi_sync <= '0;
            r_dc_sync   <= '0;
            r_sclk_hist <= 1'b0;
            r_cs_hist   <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_spi_clk};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], i_spi_cs};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_spi_mosi};
            r_dc_sync   <= {r_dc_sync[SYNC_STAGES-2:0], i_spi_dc};
            r_sclk_hist <= w_sclk;
            r_cs_hist   <= w_cs;
        end
    end

    // Bit shifter and bit counter; CS high drops any partial byte.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shift   <= 7'd0;
            r_bit_cnt <= 3'd0;
        end else if (w_rise) begin
            r_shift   <= w_byte[6:0];
            r_bit_cnt <= r_bit_cnt + 3'd1;
        end else if (w_cs) begin
            r_shift   <= 7'd0;
            r_bit_cnt <= 3'd0;
        end
    end

    // Window parameter clamping and pixel packing from the collected bytes.
    always_comb begin
        w_lim     = (r_state == ST_CASET) ? X_MAX : Y_MAX;
        w_start   = r_par[23:8];
        w_end     = {r_par[7:0], w_byte};
        w_s_clamp = (w_start > w_lim) ? w_lim : w_start;
        w_e_clamp = (w_end > w_lim) ? w_lim : w_end;
        w_e_fix   = (w_s_clamp > w_e_clamp) ? w_s_clamp : w_e_clamp;
        case (PIX_BITS)
            16:      w_pix = PIX_BITS'({r_par[7:0], w_byte});
            18:      w_pix = PIX_BITS'({r_par[15:10], r_par[7:2], w_byte[7:2]});
            default: w_pix = PIX_BITS'({r_par[15:0], w_byte});
        endcase
        if (r_x == r_xe) begin
            w_x_next = r_xs;
            w_y_next = (r_y == r_ye) ? r_ys : r_y + YW'(1);
        end else begin
            w_x_next = r_x + XW'(1);
            w_y_next = r_y;
        end
    end

    // Command decoder, window/position tracking and registered pixel outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= ST_IDLE;
            r_byte_idx     <= 2'd0;
            r_par          <= 24'd0;
            r_xs           <= XW'(0);
            r_xe           <= XW'(H_RES - 1);
            r_ys           <= YW'(0);
            r_ye           <= YW'(V_RES - 1);
            r_x            <= XW'(0);
            r_y            <= YW'(0);
            o_pixel_data   <= '0;
            o_pixel_x      <= '0;
            o_pixel_y      <= '0;
            o_pixel_en_pls <= 1'b0;
            o_vsync_pls    <= 1'b0;
        end else begin
            o_pixel_en_pls <= 1'b0;
            o_vsync_pls    <= 1'b0;
            if (w_byte_done && !w_dc) begin
                r_byte_idx <= 2'd0;
                r_par      <= 24'd0;
                case (w_byte)
                    8'h2A:   r_state <= ST_CASET;
                    8'h2B:   r_state <= ST_RASET;
                    8'h2C: begin
                        r_x         <= r_xs;
                        r_y         <= r_ys;
                        o_vsync_pls <= 1'b1;
                        r_state     <= ST_PIXEL;
                    end
                    8'h3C:   r_state <= ST_PIXEL;
                    default: r_state <= ST_IDLE;
                endcase
            end else if (w_byte_done) begin
                case (r_state)
                    ST_CASET, ST_RASET: begin
                        if (r_byte_idx == 2'd3) begin
                            if (r_state == ST_CASET) begin
                                r_xs <= XW'(w_s_clamp);
                                r_xe <= XW'(w_e_fix);
                            end else begin
                                r_ys <= YW'(w_s_clamp);
                                r_ye <= YW'(w_e_fix);
                            end
                            r_byte_idx <= 2'd0;
                            r_state    <= ST_IDLE;
                        end else begin
                            r_par      <= {r_par[15:0], w_byte};
                            r_byte_idx <= r_byte_idx + 2'd1;
                        end
                    end
                    ST_PIXEL: begin
                        if (r_byte_idx == LAST_IDX) begin
                            o_pixel_data   <= w_pix;
                            o_pixel_x      <= r_x;
                            o_pixel_y      <= r_y;
                            o_pixel_en_pls <= 1'b1;
                            r_x            <= w_x_next;
                            r_y            <= w_y_next;
                            r_byte_idx     <= 2'd0;
                        end else begin
                            r_par      <= {r_par[15:0], w_byte};
                            r_byte_idx <= r_byte_idx + 2'd1;
                        end
                    end
                    default: r_byte_idx <= 2'd0;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_spi_lcd_rx.sv
// Randomised bench for spi_lcd_rx: RGB565 and RGB666 instances share the SPI lines and are
// checked against a byte-level model of the command/window/pixel rules.
module tb_spi_lcd_rx;
    localparam int HALF = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sclk = 1'b0, cs = 1'b1, mosi = 1'b0, dc = 1'b0;
    logic [15:0] o16_data;
    logic [17:0] o18_data;
    logic [8:0]  o16_x, o16_y, o18_x, o18_y;
    logic        o16_en, o16_vs, o18_en, o18_vs;

    int n_tests = 0, n_fail = 0;
    int vs16 = 0, pulse_err = 0, hold_err = 0;
    logic p16_en = 1'b0, p16_vs = 1'b0;
    logic [33:0] last16 = '0;
    logic [41:0] obs16[$], obs18[$], exp16[$], exp18[$];
    int exp_vs = 0;

    // model state: index 0 = RGB565 instance, 1 = RGB666 instance
    int m_xs[2], m_xe[2], m_ys[2], m_ye[2], m_x[2], m_y[2];
    int m_mode;
    logic [7:0] m_par[$], m_pb16[$], m_pb18[$];

    always #5 clk = ~clk;

    spi_lcd_rx #(.PIX_BITS(16)) dut16 (
        .i_clk(clk), .i_rst_n(rst_n), .i_spi_clk(sclk), .i_spi_cs(cs), .i_spi_mosi(mosi),
        .i_spi_dc(dc), .o_pixel_data(o16_data), .o_pixel_x(o16_x), .o_pixel_y(o16_y),
        .o_pixel_en_pls(o16_en), .o_vsync_pls(o16_vs));

    spi_lcd_rx #(.PIX_BITS(18)) dut18 (
        .i_clk(clk), .i_rst_n(rst_n), .i_spi_clk(sclk), .i_spi_cs(cs), .i_spi_mosi(mosi),
        .i_spi_dc(dc), .o_pixel_data(o18_data), .o_pixel_x(o18_x), .o_pixel_y(o18_y),
        .o_pixel_en_pls(o18_en), .o_vsync_pls(o18_vs));

    // Output monitor: collects strobed pixels, counts vsyncs, watches pulse width and hold.
    always @(negedge clk) begin
        if (o16_en) obs16.push_back({8'h00, o16_data, o16_x, o16_y});
        if (o18_en) obs18.push_back({6'h00, o18_data, o18_x, o18_y});
        if (o16_vs) vs16 <= vs16 + 1;
        if ((o16_en && p16_en) || (o16_vs && p16_vs)) pulse_err <= pulse_err + 1;
        p16_en <= o16_en;
        p16_vs <= o16_vs;
        if (!rst_n) last16 <= '0;
        else if (o16_en) last16 <= {o16_data, o16_x, o16_y};
        else if ({o16_data, o16_x, o16_y} !== last16) hold_err <= hold_err + 1;
    end

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_xs[k] = 0; m_xe[k] = 479; m_ys[k] = 0; m_ye[k] = 271; m_x[k] = 0; m_y[k] = 0;
        end
        m_mode = 0;
        m_par.delete(); m_pb16.delete(); m_pb18.delete();
    endtask

    task automatic model_advance(input int k);
        if (m_x[k] == m_xe[k]) begin
            m_x[k] = m_xs[k];
            m_y[k] = (m_y[k] == m_ye[k]) ? m_ys[k] : m_y[k] + 1;
        end else begin
            m_x[k] = m_x[k] + 1;
        end
    endtask

    task automatic model_byte(input logic d, input logic [7:0] b);
        int s, e, lim, pix;
        if (!d) begin
            m_par.delete(); m_pb16.delete(); m_pb18.delete();
            case (b)
                8'h2A: m_mode = 1;
                8'h2B: m_mode = 2;
                8'h2C: begin
                    m_mode = 3;
                    exp_vs++;
                    for (int k = 0; k < 2; k++) begin m_x[k] = m_xs[k]; m_y[k] = m_ys[k]; end
                end
                8'h3C: m_mode = 3;
                default: m_mode = 0;
            endcase
        end else if (m_mode == 1 || m_mode == 2) begin
            m_par.push_back(b);
            if (m_par.size() == 4) begin
                s = int'(m_par[0]) * 256 + int'(m_par[1]);
                e = int'(m_par[2]) * 256 + int'(m_par[3]);
                lim = (m_mode == 1) ? 479 : 271;
                if (s > lim) s = lim;
                if (e > lim) e = lim;
                if (s > e) e = s;
                for (int k = 0; k < 2; k++) begin
                    if (m_mode == 1) begin m_xs[k] = s; m_xe[k] = e; end
                    else begin m_ys[k] = s; m_ye[k] = e; end
                end
                m_mode = 0;
                m_par.delete();
            end
        end else if (m_mode == 3) begin
            m_pb16.push_back(b);
            if (m_pb16.size() == 2) begin
                pix = int'(m_pb16[0]) * 256 + int'(m_pb16[1]);
                exp16.push_back({24'(pix), 9'(m_x[0]), 9'(m_y[0])});
                model_advance(0);
                m_pb16.delete();
            end
            m_pb18.push_back(b);
            if (m_pb18.size() == 3) begin
                pix = (int'(m_pb18[0]) / 4) * 4096 + (int'(m_pb18[1]) / 4) * 64 + int'(m_pb18[2]) / 4;
                exp18.push_back({24'(pix), 9'(m_x[1]), 9'(m_y[1])});
                model_advance(1);
                m_pb18.delete();
            end
        end
    endtask

    task automatic spi_bits(input logic d, input logic [7:0] b, input int n);
        dc = d;
        for (int i = 7; i > 7 - n; i--) begin
            mosi = b[i];
            repeat (HALF) @(negedge clk);
            sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
        end
        if (n == 8) model_byte(d, b);
    endtask

    task automatic cmd(input logic [7:0] b);
        spi_bits(1'b0, b, 8);
    endtask

    task automatic dat(input logic [7:0] b);
        spi_bits(1'b1, b, 8);
    endtask

    task automatic cs_set(input logic v);
        cs = v;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset();
        n_tests++;
        if ({o16_data, o16_x, o16_y, o16_en, o16_vs} !== 36'd0) begin
            n_fail++;
            $display("FAIL reset16: got %h expected 0", {o16_data, o16_x, o16_y, o16_en, o16_vs});
        end
        n_tests++;
        if ({o18_data, o18_x, o18_y, o18_en, o18_vs} !== 38'd0) begin
            n_fail++;
            $display("FAIL reset18: got %h expected 0", {o18_data, o18_x, o18_y, o18_en, o18_vs});
        end
    endtask

    task automatic test_window_wrap();
        int o0 = obs16.size(), e0 = exp16.size(), v0 = vs16;
        cmd(8'h2A); dat(8'h00); dat(8'h00); dat(8'h00); dat(8'h09);
        cmd(8'h2B); dat(8'h00); dat(8'h00); dat(8'h00); dat(8'h01);
        cmd(8'h2C);
        for (int i = 0; i < 21; i++) begin dat(8'h00); dat(8'(i)); end
        repeat (10) @(negedge clk);
        n_tests++;
        if (vs16 - v0 != 1) begin n_fail++; $display("FAIL wrap_vsync: got %0d expected 1", vs16 - v0); end
        n_tests++;
        if (obs16.size() - o0 != 21) begin n_fail++; $display("FAIL wrap_count: got %0d expected 21", obs16.size() - o0); end
        for (int i = 0; i < exp16.size() - e0 && o0 + i < obs16.size(); i++) begin
            n_tests++;
            if (obs16[o0 + i] !== exp16[e0 + i]) begin
                n_fail++; $display("FAIL wrap_pix%0d: got %h expected %h", i, obs16[o0 + i], exp16[e0 + i]);
            end
        end
        if (obs16.size() >= o0 + 21) begin
            n_tests++;
            if (obs16[o0 + 19][17:0] !== {9'd9, 9'd1}) begin n_fail++; $display("FAIL wrap_20th_xy: got %h expected (9,1)", obs16[o0 + 19][17:0]); end
            n_tests++;
            if (obs16[o0 + 20][17:0] !== 18'd0) begin n_fail++; $display("FAIL wrap_21st_xy: got %h expected (0,0)", obs16[o0 + 20][17:0]); end
        end
    endtask

    task automatic test_pix18();
        int o0 = obs18.size();
        cmd(8'h2C); dat(8'hFC); dat(8'h04); dat(8'h80);
        repeat (10) @(negedge clk);
        n_tests++;
        if (obs18.size() - o0 != 1) begin
            n_fail++; $display("FAIL pix18_count: got %0d expected 1", obs18.size() - o0);
        end else begin
            n_tests++;
            if (obs18[o0] !== {6'h00, 18'h3F060, 9'd0, 9'd0}) begin
                n_fail++; $display("FAIL pix18_value: got %h expected %h", obs18[o0], {6'h00, 18'h3F060, 18'd0});
            end
            n_tests++;
            if (obs18[o0] !== exp18[exp18.size() - 1]) begin
                n_fail++; $display("FAIL pix18_model: got %h expected %h", obs18[o0], exp18[exp18.size() - 1]);
            end
        end
    endtask

    task automatic test_clamp();
        int o0 = obs16.size(), e0 = exp16.size();
        cmd(8'h2A); dat(8'h01); dat(8'hF4); dat(8'h00); dat(8'h05);
        cmd(8'h2B); dat(8'h00); dat(8'h00); dat(8'h01); dat(8'h2C);
        cmd(8'h2C);
        for (int i = 0; i < 4; i++) begin dat(8'($urandom)); dat(8'($urandom)); end
        repeat (10) @(negedge clk);
        n_tests++;
        if (obs16.size() - o0 != 4) begin n_fail++; $display("FAIL clamp_count: got %0d expected 4", obs16.size() - o0); end
        for (int i = 0; i < 4 && o0 + i < obs16.size(); i++) begin
            n_tests++;
            if (obs16[o0 + i][17:0] !== {9'd479, 9'(i)}) begin
                n_fail++; $display("FAIL clamp_xy%0d: got %h expected (479,%0d)", i, obs16[o0 + i][17:0], i);
            end
            n_tests++;
            if (obs16[o0 + i] !== exp16[e0 + i]) begin
                n_fail++; $display("FAIL clamp_pix%0d: got %h expected %h", i, obs16[o0 + i], exp16[e0 + i]);
            end
        end
    endtask

    task automatic test_cs_ramwrc();
        int o0 = obs16.size(), e0 = exp16.size(), v0 = vs16;
        cmd(8'h2A); dat(8'h00); dat(8'h00); dat(8'h01); dat(8'hDF);
        cmd(8'h2B); dat(8'h00); dat(8'h00); dat(8'h01); dat(8'h0F);
        cmd(8'h2C); dat(8'($urandom)); dat(8'($urandom));
        cs_set(1'b1); cs_set(1'b0);
        spi_bits(1'b1, 8'($urandom), 3);
        cs_set(1'b1); cs_set(1'b0);
        cmd(8'h3C); dat(8'($urandom)); dat(8'($urandom));
        repeat (10) @(negedge clk);
        n_tests++;
        if (vs16 - v0 != 1) begin n_fail++; $display("FAIL cs_vsync: got %0d expected 1", vs16 - v0); end
        n_tests++;
        if (obs16.size() - o0 != 2) begin n_fail++; $display("FAIL cs_count: got %0d expected 2", obs16.size() - o0); end
        for (int i = 0; i < 2 && o0 + i < obs16.size(); i++) begin
            n_tests++;
            if (obs16[o0 + i] !== exp16[e0 + i]) begin
                n_fail++; $display("FAIL cs_pix%0d: got %h expected %h", i, obs16[o0 + i], exp16[e0 + i]);
            end
        end
        if (obs16.size() >= o0 + 2) begin
            n_tests++;
            if (obs16[o0 + 1][17:0] !== {9'd1, 9'd0}) begin n_fail++; $display("FAIL cs_second_xy: got %h expected (1,0)", obs16[o0 + 1][17:0]); end
        end
    endtask

    task automatic test_nop_abort();
        int o0 = obs16.size();
        logic [7:0] b0, b1;
        b0 = 8'($urandom); b1 = 8'($urandom);
        cmd(8'h2C); dat(8'($urandom)); cmd(8'h00); cmd(8'h3C); dat(b0); dat(b1);
        repeat (10) @(negedge clk);
        n_tests++;
        if (obs16.size() - o0 != 1) begin
            n_fail++; $display("FAIL nop_count: got %0d expected 1", obs16.size() - o0);
        end else begin
            n_tests++;
            if (obs16[o0] !== {8'h00, b0, b1, 18'd0}) begin
                n_fail++; $display("FAIL nop_pix: got %h expected %h", obs16[o0], {8'h00, b0, b1, 18'd0});
            end
        end
    endtask

    task automatic test_random_windows();
        int o0 = obs16.size(), e0 = exp16.size(), p0 = obs18.size(), f0 = exp18.size();
        int a, b, c, d, n;
        for (int it = 0; it < 4; it++) begin
            a = $urandom_range(0, 520); b = $urandom_range(0, 520);
            c = $urandom_range(0, 300); d = $urandom_range(0, 300);
            n = $urandom_range(1, 10);
            cmd(8'h2A); dat(8'(a >> 8)); dat(8'(a)); dat(8'(b >> 8)); dat(8'(b));
            cmd(8'h2B); dat(8'(c >> 8)); dat(8'(c)); dat(8'(d >> 8)); dat(8'(d));
            cmd(8'h2C);
            for (int i = 0; i < n; i++) begin dat(8'($urandom)); dat(8'($urandom)); end
        end
        repeat (10) @(negedge clk);
        n_tests++;
        if (obs16.size() - o0 != exp16.size() - e0) begin
            n_fail++; $display("FAIL rand_count16: got %0d expected %0d", obs16.size() - o0, exp16.size() - e0);
        end
        for (int i = 0; i < exp16.size() - e0 && o0 + i < obs16.size(); i++) begin
            n_tests++;
            if (obs16[o0 + i] !== exp16[e0 + i]) begin
                n_fail++; $display("FAIL rand_pix16_%0d: got %h expected %h", i, obs16[o0 + i], exp16[e0 + i]);
            end
        end
        n_tests++;
        if (obs18.size() - p0 != exp18.size() - f0) begin
            n_fail++; $display("FAIL rand_count18: got %0d expected %0d", obs18.size() - p0, exp18.size() - f0);
        end
        for (int i = 0; i < exp18.size() - f0 && p0 + i < obs18.size(); i++) begin
            n_tests++;
            if (obs18[p0 + i] !== exp18[f0 + i]) begin
                n_fail++; $display("FAIL rand_pix18_%0d: got %h expected %h", i, obs18[p0 + i], exp18[f0 + i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int o0, e0;
        cmd(8'h2C); dat(8'h5A); dat(8'hA5); dat(8'h3C);
        spi_bits(1'b1, 8'hFF, 4);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({o16_data, o16_x, o16_y, o16_en, o16_vs} !== 36'd0) begin
            n_fail++; $display("FAIL rstmid_out16: got %h expected 0", {o16_data, o16_x, o16_y, o16_en, o16_vs});
        end
        n_tests++;
        if ({o18_data, o18_x, o18_y, o18_en, o18_vs} !== 38'd0) begin
            n_fail++; $display("FAIL rstmid_out18: got %h expected 0", {o18_data, o18_x, o18_y, o18_en, o18_vs});
        end
        cs = 1'b1; sclk = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        o0 = obs16.size(); e0 = exp16.size();
        repeat (20) @(negedge clk);
        n_tests++;
        if (obs16.size() != o0) begin n_fail++; $display("FAIL rstmid_spurious: got %0d strobes expected 0", obs16.size() - o0); end
        cs_set(1'b0);
        cmd(8'h2C);
        for (int i = 0; i < 3; i++) begin dat(8'($urandom)); dat(8'($urandom)); end
        repeat (10) @(negedge clk);
        n_tests++;
        if (obs16.size() - o0 != 3) begin n_fail++; $display("FAIL rstmid_count: got %0d expected 3", obs16.size() - o0); end
        for (int i = 0; i < 3 && o0 + i < obs16.size(); i++) begin
            n_tests++;
            if (obs16[o0 + i] !== exp16[e0 + i]) begin
                n_fail++; $display("FAIL rstmid_pix%0d: got %h expected %h", i, obs16[o0 + i], exp16[e0 + i]);
            end
        end
    endtask

    task automatic test_pulse_shape();
        n_tests++;
        if (pulse_err != 0) begin n_fail++; $display("FAIL pulse_width: got %0d long pulses expected 0", pulse_err); end
        n_tests++;
        if (hold_err != 0) begin n_fail++; $display("FAIL output_hold: got %0d changes expected 0", hold_err); end
    endtask

    initial begin
        model_reset();
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        test_reset();
        cs_set(1'b0);
        test_window_wrap();
        test_pix18();
        test_clamp();
        test_cs_ramwrc();
        test_nop_abort();
        test_random_windows();
        test_reset_mid();
        test_pulse_shape();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/spi_lcd_rx.md
# spi_lcd_rx

Parametrised SPI receive front end for the Raspberry Pi SPI display path. It decodes the ST7789-style command stream (MIPI-DCS subset, with a D/C line) sent by the RasPi framebuffer driver. It tracks the CASET/RASET window and emits each completed pixel with its X/Y coordinates and a frame-start pulse, so the frame-buffer writer can address SDRAM/BRAM directly instead of counting pixels blindly. All SPI inputs are oversampled in the single system clock domain; there is no logic clocked by the SPI clock.

## Interface
- PIX_BITS, 16: pixel format. 16 = RGB565 (2 bytes/pixel); 18 = RGB666 (3 bytes, top 6 bits of each byte); 24 = RGB888 (3 bytes). Other values are illegal.
- H_RES, 480: panel width in pixels; X registers are $clog2(H_RES) bits wide (XW).
- V_RES, 272: panel height in pixels; Y registers are $clog2(V_RES) bits wide (YW).
- SYNC_STAGES, 2: synchroniser depth for SPI inputs (≥2).
- i_clk  in  1  system clock; the only clock.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_spi_clk  in  1  SPI SCLK, mode 0.
- i_spi_cs  in  1  SPI chip select, active low.
- i_spi_mosi  in  1  SPI MOSI, MSB first.
- i_spi_dc  in  1  0 = command byte, 1 = parameter/data byte.
- o_pixel_data  out  PIX_BITS  assembled pixel, MSB-first byte order.
- o_pixel_x  out  XW  column of o_pixel_data.
- o_pixel_y  out  YW  row of o_pixel_data.
- o_pixel_en_pls  out  1  one-cycle strobe qualifying data/x/y.
- o_vsync_pls  out  1  one-cycle strobe on every RAMWR (0x2C) command.

## Operation
- Reset values: all outputs 0; window XS=0, XE=H_RES-1, YS=0, YE=V_RES-1; X/Y position 0; state IDLE.
- Front end: SCLK, CS, MOSI and DC each pass through SYNC_STAGES flops plus one history flop. An SCLK rising edge is detected while CS is low (synchronised). On that edge, MOSI shifts into the byte register and the 3-bit bit counter increments.
- Byte complete: on the 8th edge. DC is sampled on that same edge. CS high (synchronised) clears the bit counter and discards the partial byte. Command state and the pixel byte index are kept across CS toggles.
- States: IDLE, CASET_P, RASET_P, PIXEL.
- Any command byte (DC=0) aborts the current sequence, discards any partial pixel and parameter bytes, and clears the byte index. Then:
  - 0x2A → CASET_P.
  - 0x2B → RASET_P.
  - 0x2C → X=XS, Y=YS, pulse o_vsync_pls, go to PIXEL.
  - 0x3C → go to PIXEL with X/Y unchanged.
  - Any other command → IDLE.
- CASET_P / RASET_P: collect 4 bytes in the order start[15:8], start[7:0], end[15:8], end[7:0].
  - The window is updated only on the 4th byte, then the state returns to IDLE. Extra bytes are ignored.
  - Values above H_RES-1 (X) or V_RES-1 (Y) clamp to that maximum.
  - If start > end after clamping, end := start.
- PIXEL: collect BPP bytes (2 or 3), then emit the pixel with the current X/Y.
  - 18-bit format packs bits [7:2] of each byte.
- Address advance after each pixel:
  - If X==XE: X=XS and Y advances; if also Y==YE, Y=YS (window wrap).
  - Otherwise X increments.
- DC=1 bytes in IDLE are ignored.

## Timing
- f_clk ≥ 4 × f_sclk. SCLK high and low times must each be ≥ 2 i_clk periods.
- Let D be the i_clk cycle in which the 8th SCLK rising edge is detected, i.e. SYNC_STAGES+1 cycles after the edge is sampled. Then:
  - o_pixel_en_pls and o_vsync_pls are high in cycle D+1 only.
  - o_pixel_data/x/y are valid in D+1 and hold until the next strobe.
- Window registers and state update in D+1; a strobe in D+1 uses the pre-update X/Y.
- CS rising in the same cycle as the 8th edge detection: the byte completes normally; the clear applies afterwards.
- Reset mid-transfer returns immediately to reset values. The first byte after reset requires a fresh CS low.

## Test plan
- Reset, then CASET 0,0,0,9; RASET 0,0,0,1; RAMWR; 20 RGB565 pixels 0x0000..0x0013 → one vsync pulse. Pixels emitted at (0..9,0) then (0..9,1). The 20th pixel is (9,1); a 21st pixel wraps to (0,0).
- PIX_BITS=18, RAMWR, bytes 0xFC,0x04,0x80 → o_pixel_data=18'h3F_060 style packing ({111111,000001,100000}) at (0,0).
- CASET 0x01,0xF4,0x00,0x05 (500>479) → XS clamps to 479, XE=5 raised to 479; subsequent pixels all at X=479 with Y incrementing.
- RAMWR, 1 pixel at (0,0), CS toggled high/low, RAMWRC (0x3C), 1 pixel → second pixel at (1,0) with no vsync. A 3-bit partial byte before a CS rise is discarded with no strobe.
- RAMWR, then the first byte of a pixel, then command 0x00 (NOP), then RAMWRC with 2 bytes → exactly one pixel emitted, equal to the last 2 bytes.
- Assert i_rst_n low mid-pixel → all outputs 0 at once; after release, window at defaults and no spurious strobe.
